// File: rtl/instr_realigner_pkg.sv
// Shared types for the instruction realigner: fetch-exception record, aligned
// instruction entry and half-word helpers.
package instr_realigner_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        is_compressed;
    exception_t  ex;
  } fetch_entry_t;

  localparam logic [63:0] INSTR_ALIGN_HALF = 64'd2;

  function automatic logic is_rvc(input logic [1:0] opc);
    return opc != 2'b11;
  endfunction

endpackage

// File: rtl/instr_realigner_queue.sv
// Generic circular FIFO of fetch entries; flush has priority over push and pop.
module instr_queue
  import instr_realigner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);

  // Storage is gated so an empty queue presents all-zero head fields.
  assign data_o = empty_o ? '0 : mem[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_realigner.sv
// Splits 32-bit fetch words at RVC/RV boundaries, stitching straddling 32-bit
// instructions, and queues aligned instructions for the decoder.
module instr_realigner
  import instr_realigner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [63:0] fetch_addr_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_ex_valid_i,
  input  logic [63:0] fetch_ex_cause_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [63:0] instr_pc_o,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  output logic        ex_valid_o,
  output logic [63:0] ex_cause_o,
  output logic [63:0] ex_tval_o
);

  logic [31:0]  word_q;
  logic [63:0]  addr_q;
  logic         off_q, word_v_q, word_ex_q;
  logic [63:0]  word_cause_q;
  logic [15:0]  pend_q;
  logic [63:0]  pend_pc_q;
  logic         pend_v_q;
  logic         lock_q;

  fetch_entry_t entry, head;
  logic         push, consume, set_off, set_pend, clr_pend, set_lock;
  logic         q_full, q_empty, pop, space, fetch_hs;
  logic [15:0]  upper;
  logic [63:0]  upper_pc;

  assign pop      = !q_empty & instr_ready_i;
  assign space    = !q_full | pop;
  assign upper    = word_q[31:16];
  assign upper_pc = addr_q + INSTR_ALIGN_HALF;

  always_comb begin
    push     = 1'b0;
    entry    = '0;
    consume  = 1'b0;
    set_off  = 1'b0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    set_lock = 1'b0;
    if (word_v_q && !lock_q) begin
      if (word_ex_q) begin
        if (space) begin
          push           = 1'b1;
          entry.pc       = pend_v_q ? pend_pc_q : (off_q ? upper_pc : addr_q);
          entry.ex.valid = 1'b1;
          entry.ex.cause = word_cause_q;
          entry.ex.tval  = entry.pc;
          clr_pend       = 1'b1;
          consume        = 1'b1;
          set_lock       = 1'b1;
        end
      end else if (pend_v_q) begin
        if (space) begin
          push        = 1'b1;
          entry.pc    = pend_pc_q;
          entry.instr = {word_q[15:0], pend_q};
          clr_pend    = 1'b1;
          set_off     = 1'b1;
        end
      end else if (!off_q) begin
        if (space) begin
          push     = 1'b1;
          entry.pc = addr_q;
          if (is_rvc(word_q[1:0])) begin
            entry.instr         = {16'h0, word_q[15:0]};
            entry.is_compressed = 1'b1;
            set_off             = 1'b1;
          end else begin
            entry.instr = word_q;
            consume     = 1'b1;
          end
        end
      end else if (is_rvc(upper[1:0])) begin
        if (space) begin
          push                = 1'b1;
          entry.pc            = upper_pc;
          entry.instr         = {16'h0, upper};
          entry.is_compressed = 1'b1;
          consume             = 1'b1;
        end
      end else begin
        // Lower half of a straddling instruction: no queue slot needed.
        set_pend = 1'b1;
        consume  = 1'b1;
      end
    end
  end

  // An exception word locks the fetch side until the frontend flushes.
  assign fetch_ready_o = !lock_q & (!word_v_q | (push & consume & !word_ex_q));
  assign fetch_hs      = fetch_valid_i & fetch_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q       <= '0;
      addr_q       <= '0;
      off_q        <= 1'b0;
      word_v_q     <= 1'b0;
      word_ex_q    <= 1'b0;
      word_cause_q <= '0;
      pend_q       <= '0;
      pend_pc_q    <= '0;
      pend_v_q     <= 1'b0;
      lock_q       <= 1'b0;
    end else if (flush_i) begin
      word_v_q <= 1'b0;
      pend_v_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      if (fetch_hs) begin
        word_q       <= fetch_rdata_i;
        addr_q       <= fetch_addr_i & ~64'd3;
        off_q        <= fetch_addr_i[1];
        word_v_q     <= 1'b1;
        word_ex_q    <= fetch_ex_valid_i;
        word_cause_q <= fetch_ex_cause_i;
      end else begin
        if (consume) word_v_q <= 1'b0;
        if (set_off) off_q    <= 1'b1;
      end
      if (set_pend) begin
        pend_q    <= upper;
        pend_pc_q <= upper_pc;
        pend_v_q  <= 1'b1;
      end else if (clr_pend) begin
        pend_v_q <= 1'b0;
      end
      if (set_lock) lock_q <= 1'b1;
    end
  end

  instr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign instr_valid_o   = !q_empty;
  assign instr_pc_o      = head.pc;
  assign instr_o         = head.instr;
  assign is_compressed_o = head.is_compressed;
  assign ex_valid_o      = head.ex.valid;
  assign ex_cause_o      = head.ex.cause;
  assign ex_tval_o       = head.ex.tval;

endmodule

// File: tb/tb_instr_realigner.sv
// Scoreboard bench for instr_realigner: a half-word stream model predicts the
// aligned instruction sequence, a monitor compares each consumed head entry.
module tb_instr_realigner;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        fetch_valid_i, fetch_ready_o;
  logic [63:0] fetch_addr_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ex_valid_i;
  logic [63:0] fetch_ex_cause_i;
  logic        instr_valid_o, instr_ready_i;
  logic [63:0] instr_pc_o;
  logic [31:0] instr_o;
  logic        is_compressed_o, ex_valid_o;
  logic [63:0] ex_cause_o, ex_tval_o;

  instr_realigner #(.DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_addr_i     (fetch_addr_i),
    .fetch_rdata_i    (fetch_rdata_i),
    .fetch_ex_valid_i (fetch_ex_valid_i),
    .fetch_ex_cause_i (fetch_ex_cause_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_pc_o       (instr_pc_o),
    .instr_o          (instr_o),
    .is_compressed_o  (is_compressed_o),
    .ex_valid_o       (ex_valid_o),
    .ex_cause_o       (ex_cause_o),
    .ex_tval_o        (ex_tval_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        c;
    logic        exv;
    logic [63:0] cause;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic        m_pend_v = 1'b0;
  logic [15:0] m_pend = '0;
  logic [63:0] m_pend_pc = '0;
  logic        m_lock = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic void exp_push(input logic [63:0] pc, input logic [31:0] instr,
                                   input logic c, input logic exv, input logic [63:0] cause);
    exp_t e;
    e.pc = pc; e.instr = instr; e.c = c; e.exv = exv; e.cause = cause;
    expq.push_back(e);
  endfunction

  function automatic void model_clear();
    expq.delete();
    m_pend_v = 1'b0;
    m_lock   = 1'b0;
  endfunction

  // Walk the accepted word half by half from its start offset.
  function automatic void model_fetch(input logic [63:0] addr, input logic [31:0] data,
                                      input logic ex, input logic [63:0] cause);
    logic [63:0] base;
    logic [15:0] h;
    base = {addr[63:2], 2'b00};
    if (ex) begin
      exp_push(m_pend_v ? m_pend_pc : base + (addr[1] ? 64'd2 : 64'd0), 32'h0, 1'b0, 1'b1, cause);
      m_pend_v = 1'b0;
      m_lock   = 1'b1;
      return;
    end
    for (int i = int'(addr[1]); i < 2; i++) begin
      h = data[16*i +: 16];
      if (m_pend_v) begin
        exp_push(m_pend_pc, {h, m_pend}, 1'b0, 1'b0, 64'h0);
        m_pend_v = 1'b0;
      end else if (h[1:0] != 2'b11) begin
        exp_push(base + 64'(2*i), {16'h0, h}, 1'b1, 1'b0, 64'h0);
      end else if (i == 0) begin
        exp_push(base, data, 1'b0, 1'b0, 64'h0);
        break;
      end else begin
        m_pend    = h;
        m_pend_pc = base + 64'd2;
        m_pend_v  = 1'b1;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk_i); #1;
    case (rdy_mode)
      0:       instr_ready_i = 1'b1;
      2:       instr_ready_i = 1'b0;
      default: instr_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (!rst_i && !flush_i && instr_valid_o && instr_ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual pc %h instr %h required no entry", instr_pc_o, instr_o);
      end else begin
        e = expq.pop_front();
        check("out_pc", instr_pc_o, e.pc);
        check("out_instr", 64'(instr_o), 64'(e.instr));
        check("out_compressed", 64'(is_compressed_o), 64'(e.c));
        check("out_ex_valid", 64'(ex_valid_o), 64'(e.exv));
        check("out_ex_cause", ex_cause_o, e.cause);
        check("out_ex_tval", ex_tval_o, e.exv ? e.pc : 64'h0);
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [31:0] d,
                      input logic ex, input logic [63:0] cause);
    int   t = 0;
    logic hs = 1'b0;
    fetch_valid_i    = 1'b1;
    fetch_addr_i     = a;
    fetch_rdata_i    = d;
    fetch_ex_valid_i = ex;
    fetch_ex_cause_i = cause;
    while (!hs && t < 200) begin
      @(negedge clk_i);
      hs = fetch_ready_o & !flush_i & !rst_i;
      if (hs) model_fetch(a, d, ex, cause);
      @(posedge clk_i); #1;
      t++;
    end
    fetch_valid_i = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL fetch_accept_timeout actual ready 0 required handshake at %h", a);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() > 0 && t < 500) begin
      @(posedge clk_i);
      t++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual %0d entries outstanding required 0", expq.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk_i);
    model_clear();
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(instr_valid_o), 64'h0);
    check({tag, "_pc"}, instr_pc_o, 64'h0);
    check({tag, "_instr"}, 64'(instr_o), 64'h0);
    check({tag, "_compressed"}, 64'(is_compressed_o), 64'h0);
    check({tag, "_ex_valid"}, 64'(ex_valid_o), 64'h0);
    check({tag, "_ex_cause"}, ex_cause_o, 64'h0);
    check({tag, "_ex_tval"}, ex_tval_o, 64'h0);
  endtask

  function automatic logic [31:0] rand_word();
    return $urandom;
  endfunction

  initial begin
    logic [63:0] addr;
    int          r;
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_addr_i = '0;
    fetch_rdata_i = '0; fetch_ex_valid_i = 1'b0; fetch_ex_cause_i = '0; instr_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    check("reset_fetch_ready", 64'(fetch_ready_o), 64'h1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 32-bit aligned instruction and its latency
    send(64'h8000_0000, 32'h00A00513, 1'b0, 64'h0);
    @(negedge clk_i); check("latency_cycle1_valid", 64'(instr_valid_o), 64'h0);
    @(negedge clk_i); check("latency_cycle2_valid", 64'(instr_valid_o), 64'h1);
    @(posedge clk_i); #1;
    drain();

    // two compressed in one word
    send(64'h1000, 32'h40014501, 1'b0, 64'h0);
    @(negedge clk_i); check("two_rvc_ready_low", 64'(fetch_ready_o), 64'h0);
    @(negedge clk_i); check("two_rvc_ready_high", 64'(fetch_ready_o), 64'h1);
    @(posedge clk_i); #1;
    drain();

    // straddling 32-bit instruction
    send(64'h2000, 32'h05134501, 1'b0, 64'h0);
    send(64'h2004, 32'h000000A0, 1'b0, 64'h0);
    drain();

    // start at upper half
    send(64'h3002, 32'h45051234, 1'b0, 64'h0);
    drain();

    // exception with a pending lower half
    send(64'h3FFC, 32'h05134501, 1'b0, 64'h0);
    send(64'h4000, 32'h12345678, 1'b1, 64'h1);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); check("ex_lock_ready", 64'(fetch_ready_o), 64'h0);
    end
    @(posedge clk_i); #1;
    do_flush();
    @(negedge clk_i); check("ex_unlock_ready", 64'(fetch_ready_o), 64'h1);
    @(posedge clk_i); #1;

    // full queue, then flush with a push pending
    rdy_mode = 2; instr_ready_i = 1'b0;
    @(posedge clk_i); #1;
    send(64'h5000, 32'h40014501, 1'b0, 64'h0);
    send(64'h5004, 32'h40054505, 1'b0, 64'h0);
    send(64'h5008, 32'h40094509, 1'b0, 64'h0);
    repeat (3) @(negedge clk_i);
    check("full_valid", 64'(instr_valid_o), 64'h1);
    check("full_fetch_stall", 64'(fetch_ready_o), 64'h0);
    check("full_head_pc", instr_pc_o, 64'h5000);
    @(posedge clk_i); #1;
    rdy_mode = 0; instr_ready_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_addr_i = 64'h6000; fetch_rdata_i = 32'h40014501;
    do_flush();
    fetch_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_flush_valid", 64'(instr_valid_o), 64'h0);
      check("post_flush_pc", instr_pc_o, 64'h0);
    end
    @(negedge clk_i); check("post_flush_ready", 64'(fetch_ready_o), 64'h1);
    @(posedge clk_i); #1;

    // asynchronous reset mid-stream
    rdy_mode = 2;
    @(posedge clk_i); #1;
    send(64'h7000, 32'h45054505, 1'b0, 64'h0);
    repeat (3) @(negedge clk_i);
    check("pre_reset_valid", 64'(instr_valid_o), 64'h1);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    model_clear();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("post_reset_ready", 64'(fetch_ready_o), 64'h1);

    // randomized stream with random back-pressure, flushes and exceptions
    rdy_mode = 1;
    addr = {32'h0, $urandom} & ~64'd3;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        send(addr, rand_word(), 1'b1, {$urandom, $urandom});
        drain();
        do_flush();
        addr = {$urandom, $urandom} & ~64'd1;
      end else if (r < 7) begin
        do_flush();
        addr = (r == 6) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom, $urandom} & ~64'd1);
      end else begin
        send(addr, rand_word(), 1'b0, 64'h0);
        addr = {addr[63:2], 2'b00} + 64'd4;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
